// File: rtl/pwm_peripheral.sv
// pwm_peripheral: three-state output stage driving uo/uio from a shared PWM.
// Optional macro PWM_SYNC_UPDATE_EN: duty changes take effect at period start.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_out_uo,
  input  logic [7:0] en_out_uio,
  input  logic [7:0] en_pwm_uo,
  input  logic [7:0] en_pwm_uio,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_uo,
  output logic [7:0] out_uio,
  output logic       period_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0] CNT_MAX = 8'd254;

  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_nxt;
  logic [7:0]    pwm_cnt;
  logic [7:0]    pwm_cnt_nxt;
  logic          tick;
  logic          boundary;
  logic [7:0]    duty_eff;
  logic          pwm_level;
  logic [7:0]    next_uo;
  logic [7:0]    next_uio;

  assign tick     = (prescaler == PS_MAX);
  assign boundary = (pwm_cnt == 8'd0) && (prescaler == '0);

  always_comb begin
    prescaler_nxt = prescaler + 1'b1;
    pwm_cnt_nxt   = pwm_cnt;
    if (tick) begin
      prescaler_nxt = '0;
      pwm_cnt_nxt   = (pwm_cnt == CNT_MAX) ? 8'd0 : pwm_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= prescaler_nxt;
      pwm_cnt   <= pwm_cnt_nxt;
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0] duty_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_active <= '0;
    end else if (boundary) begin
      duty_active <= pwm_duty_cycle;
    end
  end

  // The boundary cycle already belongs to the new period, so it
  // must compare against the value being loaded, not the old one.
  assign duty_eff = boundary ? pwm_duty_cycle : duty_active;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  assign pwm_level = (duty_eff == 8'hFF) || (pwm_cnt < duty_eff);

  assign next_uo  = en_out_uo  & (~en_pwm_uo  | {8{pwm_level}});
  assign next_uio = en_out_uio & (~en_pwm_uio | {8{pwm_level}});

  always_ff @(posedge clk) begin
    if (rst) begin
      out_uo       <= '0;
      out_uio      <= '0;
      period_start <= 1'b0;
    end else begin
      out_uo       <= next_uo;
      out_uio      <= next_uio;
      period_start <= boundary;
    end
  end

endmodule
